// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between decode/regfile and the iterative RV32M multiply/divide unit.
// The master drives issue operands; the slave returns busy and the register-file write request.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            busy;
  logic            we_out;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] wd_out;

  modport master (
    output start, kill, funct3, rd, rs1_val, rs2_val,
    input  busy, we_out, rd_out, wd_out
  );

  modport slave (
    input  start, kill, funct3, rd, rs1_val, rs2_val,
    output busy, we_out, rd_out, wd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: one bit per cycle over XLEN cycles, div-by-zero/overflow finish in one cycle.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; results are identical, only latency changes.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(XLEN);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [4:0]      rd_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [4:0]      rd_out_q;
  logic [XLEN-1:0] wd_out_q;

  logic            accept, last;
  logic            is_div_in, sa_in, sb_in, div0_in, ovf_in, quick_in;
  logic [XLEN-1:0] amag_in, bmag_in, quick_res;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  // Sign fix-up shared by the iterative and single-cycle paths; {h,l} is the raw magnitude result.
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] f, input logic nq, input logic nr,
                                               input logic [XLEN-1:0] h, input logic [XLEN-1:0] l);
    logic [2*XLEN-1:0] p;
    p = nq ? -{h, l} : {h, l};
    if (!f[2])
      finalize = (f[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else if (f[1])
      finalize = nr ? -h : h;
    else
      finalize = nq ? -l : l;
  endfunction

  always_comb begin
    is_div_in = bus.funct3[2];
    sa_in     = bus.rs1_val[XLEN-1] && (bus.funct3 == 3'd1 || bus.funct3 == 3'd2 ||
                                        bus.funct3 == 3'd4 || bus.funct3 == 3'd6);
    sb_in     = bus.rs2_val[XLEN-1] && (bus.funct3 == 3'd1 || bus.funct3 == 3'd4 ||
                                        bus.funct3 == 3'd6);
    amag_in   = sa_in ? -bus.rs1_val : bus.rs1_val;
    bmag_in   = sb_in ? -bus.rs2_val : bus.rs2_val;
    div0_in   = is_div_in && (bus.rs2_val == '0);
    ovf_in    = is_div_in && !bus.funct3[0] && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                (&bus.rs2_val);
    quick_in  = div0_in || ovf_in;
    quick_res = '0;
    if (div0_in)
      quick_res = bus.funct3[1] ? bus.rs1_val : '1;
    else if (ovf_in)
      quick_res = bus.funct3[1] ? '0 : bus.rs1_val;
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div_in) begin
      logic [2*XLEN-1:0] full;
      full      = {{XLEN{1'b0}}, amag_in} * {{XLEN{1'b0}}, bmag_in};
      quick_res = finalize(bus.funct3, sa_in ^ sb_in, sa_in, full[2*XLEN-1:XLEN], full[XLEN-1:0]);
    end
    quick_in = quick_in || !is_div_in;
`endif
  end

  // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  // Divide: restoring step with the quotient shifting into acc_lo as the dividend shifts out.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (op[2]) begin
      hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_nxt = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.kill) begin
        accept    = 1'b1;
        state_nxt = quick_in ? DONE : CALC;
      end
      CALC: begin
        last = (cnt == CW'(XLEN-1));
        if (bus.kill)  state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op       <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      rd_out_q <= '0;
      wd_out_q <= '0;
    end else if (accept) begin
      op     <= bus.funct3;
      rd_q   <= bus.rd;
      neg_q  <= sa_in ^ sb_in;
      neg_r  <= sa_in;
      opnd   <= is_div_in ? bmag_in : amag_in;
      acc_lo <= is_div_in ? amag_in : bmag_in;
      acc_hi <= '0;
      cnt    <= '0;
      if (quick_in) begin
        rd_out_q <= bus.rd;
        wd_out_q <= quick_res;
      end
    end else if (state == CALC && !bus.kill) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= last ? '0 : cnt + 1'b1;
      if (last) begin
        rd_out_q <= rd_q;
        wd_out_q <= finalize(op, neg_q, neg_r, hi_nxt, lo_nxt);
      end
    end
  end

  // kill masks the strobe combinationally so a kill in DONE still suppresses the write.
  assign bus.busy   = (state != IDLE);
  assign bus.we_out = (state == DONE) && (rd_out_q != 5'd0) && !bus.kill;
  assign bus.rd_out = rd_out_q;
  assign bus.wd_out = wd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, busy length, kill and reset behaviour.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, then watch busy/we_out for a bounded window after the accept edge.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int kill_at, input int restart_at);
    int nb, nw, wcyc;
    logic [31:0] wd;
    logic [4:0]  rdo;
    nb = 0; nw = 0; wcyc = 0; wd = '0; rdo = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.rd = r; bus.rs1_val = a; bus.rs2_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rs1_val = $urandom; bus.rs2_val = $urandom;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.we_out) begin
        nw++; wcyc = k; wd = bus.wd_out; rdo = bus.rd_out;
      end
      bus.kill  = (k == kill_at);
      bus.start = (k == restart_at);
    end
    bus.kill = 1'b0;
    bus.start = 1'b0;
    check({tag, ".busy_cycles"}, nb, (kill_at > 0) ? kill_at : lat);
    check({tag, ".writes"}, nw, (kill_at == 0 && r != 5'd0) ? 1 : 0);
    if (nw > 0) begin
      check({tag, ".latency"}, wcyc, lat);
      check({tag, ".rd_out"}, rdo, r);
      check({tag, ".wd_out"}, wd, exp);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.rd = '0;
    bus.rs1_val = '0; bus.rs2_val = '0;
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.we_out", bus.we_out, 0);
    check("reset.rd_out", bus.rd_out, 0);
    check("reset.wd_out", bus.wd_out, 0);
    #12 rst = 1'b0;

    run_op("mul",      3'd0, 5'd7,  32'h0000A61F, 32'h00001F01, 32'h141E671F, ML, 0, 0);
    run_op("divu",     3'd5, 5'd3,  32'h0000A61F, 32'h00001F01, 32'h00000005, DL, 0, 0);
    run_op("remu",     3'd7, 5'd4,  32'h0000A61F, 32'h00001F01, 32'h00000B1A, DL, 0, 0);
    run_op("div0",     3'd4, 5'd5,  32'h0000A61F, 32'h00000000, 32'hFFFFFFFF, 1,  0, 0);
    run_op("rem0",     3'd6, 5'd6,  32'h0000A61F, 32'h00000000, 32'h0000A61F, 1,  0, 0);
    run_op("remu0",    3'd7, 5'd8,  32'h12345678, 32'h00000000, 32'h12345678, 1,  0, 0);
    run_op("div_ovf",  3'd4, 5'd9,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, 0);
    run_op("rem_ovf",  3'd6, 5'd10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0, 0);
    run_op("mulh_m1",  3'd1, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML, 0, 0);
    run_op("mulhu_m1", 3'd3, 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML, 0, 0);
    run_op("mulhsu",   3'd2, 5'd13, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, ML, 0, 0);
    run_op("mulh_min", 3'd1, 5'd14, 32'h80000000, 32'h80000000, 32'h40000000, ML, 0, 0);
    run_op("mulhsu_mn",3'd2, 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ML, 0, 0);
    run_op("mul_neg",  3'd0, 5'd16, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, ML, 0, 0);
    run_op("div_n7_2", 3'd4, 5'd17, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DL, 0, 0);
    run_op("rem_n7_2", 3'd6, 5'd18, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DL, 0, 0);
    run_op("div_7_n2", 3'd4, 5'd19, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DL, 0, 0);
    run_op("rem_7_n2", 3'd6, 5'd20, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, DL, 0, 0);

    run_op("restart",  3'd5, 5'd21, 32'h00000064, 32'h00000007, 32'h0000000E, DL, 0, 5);
    run_op("rd_zero",  3'd5, 5'd0,  32'h00000064, 32'h00000007, 32'h0000000E, DL, 0, 0);
    run_op("kill",     3'd5, 5'd22, 32'h00000064, 32'h00000007, 32'h0000000E, DL, 10, 0);

    // Reset in the middle of a divide: outputs return to zero without waiting for a clock.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rd = 5'd23;
    bus.rs1_val = 32'h00000064; bus.rs2_val = 32'h00000007;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_rst.busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst.busy", bus.busy, 0);
    check("mid_rst.we_out", bus.we_out, 0);
    check("mid_rst.rd_out", bus.rd_out, 0);
    check("mid_rst.wd_out", bus.wd_out, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'd0, 5'd7, 32'h0000A61F, 32'h00001F01, 32'h141E671F, ML, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
